// File: rtl/instr_fetch_reg.sv
// ---------------------------------------------------------------------------
// instr_fetch_reg
//   Fetch stage + instruction register for the RV64I multicycle core.
//   Holds the fetch PC, issues word requests to instruction memory using a
//   ready handshake with a bounded wait, latches the returned instruction and
//   presents it, with decoded fields, to the sign-extender and control unit.
//   A branch/jump redirect may arrive at any time. A misaligned fetch or a
//   memory timeout raises a sticky fault that only reset clears.
//
// Ports
//   i_clk, i_reset        clock; synchronous active-high reset
//   i_fetch_en            start a fetch (sampled in IDLE only)
//   i_pc_load, i_pc_in    redirect: next fetch address becomes i_pc_in
//   o_imem_req/addr       instruction memory request and word address
//   i_imem_ready/rdata    memory response (rdata valid while ready)
//   o_instr               instruction register (NOP after reset)
//   o_opcode..o_rs2       decode fields, combinational from o_instr
//   o_instr_pc            address o_instr was fetched from
//   o_fetch_pc            address of the next sequential fetch
//   o_ir_valid            o_instr holds a completed fetch
//   o_busy                a request is outstanding
//   o_fetch_fault         sticky misaligned/timeout fault
// ---------------------------------------------------------------------------
module instr_fetch_reg #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          TIMEOUT  = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_fetch_en,
    input  logic        i_pc_load,
    input  logic [63:0] i_pc_in,
    output logic        o_imem_req,
    output logic [63:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic [6:0]  o_opcode,
    output logic [4:0]  o_rd,
    output logic [2:0]  o_funct3,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [63:0] o_instr_pc,
    output logic [63:0] o_fetch_pc,
    output logic        o_ir_valid,
    output logic        o_busy,
    output logic        o_fetch_fault
);

    localparam logic [31:0] NOP = 32'h0000_0013;
    // Counter must be able to hold TIMEOUT itself.
    localparam int          CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Value of the counter during the last BUSY cycle that may still complete.
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FAULT} state_t;

    state_t        r_state, w_next;
    logic [63:0]   r_fetch_pc, r_instr_pc, r_imem_addr, r_redir_pc;
    logic [31:0]   r_instr;
    logic          r_ir_valid, r_imem_req, r_fault, r_redir_pend;
    logic [CW-1:0] r_tcnt;

    logic [63:0]   w_addr, w_next_pc;
    logic          w_misalign, w_start, w_bad, w_done, w_tmo, w_save, w_idle_load;

    // Address a fetch started this cycle would use; a same-cycle redirect wins.
    assign w_addr     = i_pc_load ? i_pc_in : r_fetch_pc;
    assign w_misalign = |w_addr[1:0];

    // ---- state register ----
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // ---- next-state logic ----
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_fetch_en) w_next = w_misalign ? S_FAULT : S_BUSY;
            // Ready in the timeout cycle still completes the fetch.
            S_BUSY:  if (i_imem_ready)     w_next = S_IDLE;
                     else if (r_tcnt == TLAST) w_next = S_FAULT;
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_IDLE;
        endcase
    end

    // ---- output / strobe logic ----
    always_comb begin
        w_start     = (r_state == S_IDLE) &&  i_fetch_en && !w_misalign;
        w_bad       = (r_state == S_IDLE) &&  i_fetch_en &&  w_misalign;
        w_idle_load = (r_state == S_IDLE) && !i_fetch_en &&  i_pc_load;
        w_done      = (r_state == S_BUSY) &&  i_imem_ready;
        w_tmo       = (r_state == S_BUSY) && !i_imem_ready && (r_tcnt == TLAST);
        w_save      = (r_state == S_BUSY) && !i_imem_ready &&  i_pc_load;
        // Redirect priority at completion: this cycle, then saved, then +4.
        w_next_pc   = i_pc_load    ? i_pc_in    :
                      r_redir_pend ? r_redir_pc : r_imem_addr + 64'd4;
    end

    // ---- datapath ----
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fetch_pc   <= RESET_PC;
            r_instr_pc   <= '0;
            r_instr      <= NOP;
            r_ir_valid   <= 1'b0;
            r_imem_req   <= 1'b0;
            r_imem_addr  <= '0;
            r_fault      <= 1'b0;
            r_redir_pend <= 1'b0;
            r_redir_pc   <= '0;
            r_tcnt       <= '0;
        end else begin
            if (w_start) begin
                r_imem_req   <= 1'b1;
                r_imem_addr  <= w_addr;
                r_fetch_pc   <= w_addr;
                r_ir_valid   <= 1'b0;
                r_redir_pend <= 1'b0;
                r_tcnt       <= '0;
            end
            if (w_bad) r_fault <= 1'b1;
            if (w_idle_load) r_fetch_pc <= i_pc_in;

            if (w_done) begin
                r_instr      <= i_imem_rdata;
                r_instr_pc   <= r_imem_addr;
                r_ir_valid   <= 1'b1;
                r_imem_req   <= 1'b0;
                r_fetch_pc   <= w_next_pc;
                r_redir_pend <= 1'b0;
            end else if (r_state == S_BUSY) begin
                r_tcnt <= r_tcnt + 1'b1;
            end

            // Latest redirect during the wait replaces any earlier one.
            if (w_save) begin
                r_redir_pend <= 1'b1;
                r_redir_pc   <= i_pc_in;
            end
            if (w_tmo) begin
                r_fault    <= 1'b1;
                r_imem_req <= 1'b0;
            end
        end
    end

    assign o_imem_req    = r_imem_req;
    assign o_imem_addr   = r_imem_addr;
    assign o_instr       = r_instr;
    assign o_opcode      = r_instr[6:0];
    assign o_rd          = r_instr[11:7];
    assign o_funct3      = r_instr[14:12];
    assign o_rs1         = r_instr[19:15];
    assign o_rs2         = r_instr[24:20];
    assign o_instr_pc    = r_instr_pc;
    assign o_fetch_pc    = r_fetch_pc;
    assign o_ir_valid    = r_ir_valid;
    assign o_busy        = (r_state == S_BUSY);
    assign o_fetch_fault = r_fault;

endmodule

// File: tb/tb_instr_fetch_reg.sv
module tb_instr_fetch_reg;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int          TIMEOUT  = 15;

    logic        clk = 1'b0;
    logic        reset, fetch_en, pc_load, imem_ready;
    logic [63:0] pc_in;
    logic [31:0] imem_rdata;
    logic        imem_req, ir_valid, busy, fetch_fault;
    logic [63:0] imem_addr, instr_pc, fetch_pc;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_reg #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_reset(reset), .i_fetch_en(fetch_en), .i_pc_load(pc_load),
        .i_pc_in(pc_in), .o_imem_req(imem_req), .o_imem_addr(imem_addr),
        .i_imem_ready(imem_ready), .i_imem_rdata(imem_rdata), .o_instr(instr),
        .o_opcode(opcode), .o_rd(rd), .o_funct3(funct3), .o_rs1(rs1), .o_rs2(rs2),
        .o_instr_pc(instr_pc), .o_fetch_pc(fetch_pc), .o_ir_valid(ir_valid),
        .o_busy(busy), .o_fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        ld;
        logic [63:0] pc;
        int          waits;
        int          redir_at;   // BUSY cycle carrying a redirect, 0 = none
        logic [63:0] redir_pc;
        logic [31:0] rdata;
        logic [63:0] e_ipc;      // also the expected request address
        logic [63:0] e_fpc;
    } vec_t;

    vec_t tv[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        fetch_en = 0; pc_load = 0; pc_in = '0; imem_ready = 0; imem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1; tick(); reset = 0;
    endtask

    // One fetch with a single optional redirect; caller guarantees waits < TIMEOUT.
    task automatic run_fetch(input vec_t v);
        fetch_en = 1; pc_load = v.ld; pc_in = v.pc;
        tick();
        fetch_en = 0; pc_load = 0;
        chk("req_start", imem_req, 1);
        chk("addr_start", imem_addr, v.e_ipc);
        chk("irv_clear", ir_valid, 0);
        for (int k = 1; k <= v.waits + 1; k++) begin
            imem_ready = (k == v.waits + 1);
            imem_rdata = imem_ready ? v.rdata : $urandom;
            pc_load    = (k == v.redir_at);
            pc_in      = v.redir_pc;
            fetch_en   = 1'($urandom);
            tick();
            idle_inputs();
            if (k <= v.waits) begin
                chk("busy_req", imem_req, 1);
                chk("busy_addr", imem_addr, v.e_ipc);
                chk("busy_flag", busy, 1);
            end
        end
    endtask

    logic [63:0] mfpc, addr, exp_next, rpc;
    logic [31:0] exp_rd;
    int          nw;
    logic        ld;

    initial begin
        tv[0] = '{1'b0, 64'h0, 0, 0, 64'h0, 32'h0050_0093, 64'h0, 64'h4};
        tv[1] = '{1'b0, 64'h0, 3, 2, 64'h100, 32'h00A0_0113, 64'h4, 64'h100};
        tv[2] = '{1'b0, 64'h0, 1, 0, 64'h0, 32'h0020_81B3, 64'h100, 64'h104};
        tv[3] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 64'h0, 32'hFE01_0113,
                  64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
        tv[4] = '{1'b0, 64'h0, 14, 5, 64'h200, 32'h0000_0073, 64'h0, 64'h200};
        tv[5] = '{1'b1, 64'h40, 2, 3, 64'h80, 32'h0031_0233, 64'h40, 64'h80};

        do_reset();
        chk("rst_fetch_pc", fetch_pc, RESET_PC);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_instr", instr, 32'h13);
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fetch_fault, 0);

        // table-driven fetches, chained from reset
        for (int i = 0; i < 6; i++) begin
            run_fetch(tv[i]);
            chk($sformatf("v%0d_instr", i), instr, tv[i].rdata);
            chk($sformatf("v%0d_instr_pc", i), instr_pc, tv[i].e_ipc);
            chk($sformatf("v%0d_fetch_pc", i), fetch_pc, tv[i].e_fpc);
            chk($sformatf("v%0d_ir_valid", i), ir_valid, 1);
            chk($sformatf("v%0d_req_off", i), imem_req, 0);
            chk($sformatf("v%0d_fault", i), fetch_fault, 0);
            if (i == 0) begin
                chk("v0_opcode", opcode, 7'h13);
                chk("v0_rd", rd, 1);
                chk("v0_funct3", funct3, 0);
                chk("v0_rs1", rs1, 0);
                chk("v0_rs2", rs2, 5);
            end
        end

        // ready outside BUSY is ignored; IR holds
        imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
        tick(); tick();
        idle_inputs();
        chk("idle_ready_instr", instr, 32'h0031_0233);
        chk("idle_ready_irv", ir_valid, 1);
        chk("idle_ready_busy", busy, 0);

        // reset in the 2nd BUSY cycle abandons the request
        fetch_en = 1; tick(); fetch_en = 0;
        tick();
        reset = 1; tick(); reset = 0;
        chk("midrst_req", imem_req, 0);
        chk("midrst_instr", instr, 32'h13);
        chk("midrst_irv", ir_valid, 0);
        chk("midrst_fetch_pc", fetch_pc, RESET_PC);
        chk("midrst_busy", busy, 0);

        // misaligned redirect with fetch_en -> sticky fault, never a request
        fetch_en = 1; pc_load = 1; pc_in = 64'h102;
        tick();
        chk("mis_fault", fetch_fault, 1);
        chk("mis_req", imem_req, 0);
        for (int k = 0; k < 4; k++) begin
            fetch_en = 1; pc_load = 1'($urandom); pc_in = 64'h200; imem_ready = 1;
            tick();
            chk("mis_hold_fault", fetch_fault, 1);
            chk("mis_hold_req", imem_req, 0);
        end
        do_reset();
        chk("mis_rst_fault", fetch_fault, 0);

        // timeout: no ready for TIMEOUT BUSY cycles
        fetch_en = 1; tick(); fetch_en = 0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            if (k < TIMEOUT) chk("tmo_pre_fault", fetch_fault, 0);
        end
        chk("tmo_fault", fetch_fault, 1);
        chk("tmo_req", imem_req, 0);
        chk("tmo_busy", busy, 0);
        do_reset();
        chk("tmo_rst_fault", fetch_fault, 0);

        // randomized transactions against a transaction-level model
        mfpc = RESET_PC;
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 4) == 0) begin
                pc_load = 1; pc_in = {$urandom, $urandom} & ~64'h3;
                imem_ready = 1'($urandom); imem_rdata = $urandom;
                mfpc = pc_in;
                tick(); idle_inputs();
                chk("rnd_idle_load", fetch_pc, mfpc);
            end
            ld  = 1'($urandom);
            rpc = {$urandom, $urandom};
            if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
            addr = ld ? rpc : mfpc;
            fetch_en = 1; pc_load = ld; pc_in = rpc;
            tick(); idle_inputs();
            if (addr[1:0] != 2'b00) begin
                chk("rnd_mis_fault", fetch_fault, 1);
                chk("rnd_mis_req", imem_req, 0);
                do_reset(); mfpc = RESET_PC;
                continue;
            end
            chk("rnd_addr", imem_addr, addr);
            nw = $urandom_range(0, TIMEOUT + 1);
            exp_next = addr + 64'd4;
            exp_rd = '0;
            for (int k = 1; k <= TIMEOUT; k++) begin
                imem_ready = (k == nw + 1);
                imem_rdata = $urandom;
                if (imem_ready) exp_rd = imem_rdata;
                pc_load = ($urandom_range(0, 3) == 0);
                pc_in   = {$urandom, $urandom};
                if (pc_load) exp_next = pc_in;
                tick(); idle_inputs();
                if (k == nw + 1) break;
            end
            if (nw < TIMEOUT) begin
                chk("rnd_instr", instr, exp_rd);
                chk("rnd_opcode", opcode, exp_rd[6:0]);
                chk("rnd_instr_pc", instr_pc, addr);
                chk("rnd_fetch_pc", fetch_pc, exp_next);
                chk("rnd_irv", ir_valid, 1);
                chk("rnd_nofault", fetch_fault, 0);
                mfpc = exp_next;
            end else begin
                chk("rnd_tmo_fault", fetch_fault, 1);
                chk("rnd_tmo_req", imem_req, 0);
                do_reset(); mfpc = RESET_PC;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
